// File: rtl/l0_sram_loader.sv
// Activation SRAM to l0 row FIFO loader.
// Streams N consecutive vectors through a 2-entry skid buffer under l0 back-pressure.
module l0_sram_loader #(
    parameter int bw     = 4,
    parameter int col    = 8,
    parameter int addr_w = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [addr_w-1:0]   i_base_addr,
    input  logic [addr_w:0]     i_num_vec,
    output logic                o_sram_ren,
    output logic [addr_w-1:0]   o_sram_addr,
    input  logic [bw*col-1:0]   i_sram_q,
    output logic                o_l0_wr,
    output logic [bw*col-1:0]   o_l0_in,
    input  logic                i_l0_ready,
    output logic                o_busy,
    output logic                o_done
);

    localparam int dw = bw * col;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_n;
    logic [addr_w-1:0] base;
    logic [addr_w:0]   count;
    logic [addr_w:0]   issued;
    logic [addr_w:0]   written;
    logic [addr_w:0]   written_n;
    logic              inflight;
    logic [1:0]        occ;
    logic [dw-1:0]     skid0, skid1;
    logic [dw-1:0]     e0, e1;
    logic [2:0]        level;
    logic              run;
    logic              have;

    // The word arriving from SRAM this cycle acts as the buffer tail, so
    // it can be written straight through when the buffer is empty.
    always_comb begin
        run         = (state == RUN);
        have        = (occ != 2'd0) || inflight;
        e0          = (occ != 2'd0) ? skid0 : i_sram_q;
        e1          = (occ == 2'd2) ? skid1 : i_sram_q;
        o_l0_wr     = run && have && i_l0_ready;
        o_l0_in     = (run && have) ? e0 : '0;
        level       = {1'b0, occ} + {2'b0, inflight} - {2'b0, o_l0_wr};
        o_sram_ren  = run && (issued < count) && (level < 3'd2);
        o_sram_addr = run ? base + issued[addr_w-1:0] : '0;
        o_busy      = (state != IDLE);
        o_done      = (state == DONE);
        written_n   = written + {{addr_w{1'b0}}, o_l0_wr};
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (i_start)
                    state_n = (i_num_vec == '0) ? DONE : RUN;
            end
            RUN: begin
                if (written_n == count)
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            base     <= '0;
            count    <= '0;
            issued   <= '0;
            written  <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            skid0    <= '0;
            skid1    <= '0;
        end else begin
            state    <= state_n;
            inflight <= o_sram_ren;
            occ      <= level[1:0];
            skid0    <= o_l0_wr ? e1 : e0;
            skid1    <= e1;
            if (state == IDLE && i_start) begin
                base    <= i_base_addr;
                count   <= i_num_vec;
                issued  <= '0;
                written <= '0;
            end else begin
                if (o_sram_ren)
                    issued <= issued + 1'b1;
                written <= written_n;
            end
        end
    end

endmodule

// File: tb/tb_l0_sram_loader.sv
// Bench for l0_sram_loader: scenario table plus hand-written reset abort.
// SRAM model and address/data scoreboard queues live here.
module tb_l0_sram_loader;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [AW:0]   i_num_vec;
    logic          o_sram_ren;
    logic [AW-1:0] o_sram_addr;
    logic [DW-1:0] i_sram_q;
    logic          o_l0_wr;
    logic [DW-1:0] o_l0_in;
    logic          i_l0_ready;
    logic          o_busy;
    logic          o_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   num;
        int            lo;
        int            hi;
        int            s2;
        int            exp_done;
    } vec_t;

    vec_t          tbl[6];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];

    l0_sram_loader #(.bw(4), .col(8), .addr_w(AW)) dut (
        .clk(clk),
        .reset(reset),
        .i_start(i_start),
        .i_base_addr(i_base_addr),
        .i_num_vec(i_num_vec),
        .o_sram_ren(o_sram_ren),
        .o_sram_addr(o_sram_addr),
        .i_sram_q(i_sram_q),
        .o_l0_wr(o_l0_wr),
        .o_l0_in(o_l0_in),
        .i_l0_ready(i_l0_ready),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return {a, ~a, 5'h15, 5'h0A};
    endfunction

    // One-cycle-latency SRAM; garbage when not read.
    always @(posedge clk)
        i_sram_q <= o_sram_ren ? word(o_sram_addr) : 32'hDEADBEEF;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_scn(input vec_t v);
        int  rens;
        int  wrs;
        int  done_cyc;
        bit  fin;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        rens = 0;
        wrs = 0;
        done_cyc = -1;
        fin = 0;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < int'(v.num); i++) begin
            a = v.base + AW'(i);
            exp_addr.push_back(a);
            exp_data.push_back(word(a));
        end
        @(negedge clk);
        i_start = 1'b1;
        i_base_addr = v.base;
        i_num_vec = v.num;
        i_l0_ready = 1'b1;
        for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
            @(negedge clk);
            i_start = (cyc == v.s2);
            i_base_addr = 11'h100;
            i_num_vec = 12'd3;
            i_l0_ready = !(cyc >= v.lo && cyc <= v.hi);
            #1;
            chk(rens - wrs <= 2, "held_max", rens - wrs, 2);
            chk(o_busy === 1'b1, "busy_run", o_busy, 1);
            if (o_sram_ren) begin
                rens++;
                if (exp_addr.size() == 0) begin
                    chk(0, "ren_extra", o_sram_addr, 0);
                end else begin
                    a = exp_addr.pop_front();
                    chk(o_sram_addr === a, "ren_addr", o_sram_addr, a);
                end
            end
            if (o_l0_wr) begin
                wrs++;
                if (exp_data.size() == 0) begin
                    chk(0, "wr_extra", o_l0_in, 0);
                end else begin
                    d = exp_data.pop_front();
                    chk(o_l0_in === d, "wr_data", o_l0_in, d);
                end
            end
            if (o_done) begin
                done_cyc = cyc;
                fin = 1;
            end
        end
        chk(done_cyc == v.exp_done, "done_cycle", done_cyc, v.exp_done);
        chk(rens == int'(v.num), "ren_count", rens, v.num);
        chk(wrs == int'(v.num), "wr_count", wrs, v.num);
        @(negedge clk);
        i_start = 1'b0;
        i_l0_ready = 1'b1;
        #1;
        chk(!o_busy && !o_done, "idle_after", {o_busy, o_done}, 0);
    endtask

    initial begin
        tbl[0] = '{base: 11'h010, num: 12'd4, lo: 0, hi: 0, s2: 0, exp_done: 6};
        tbl[1] = '{base: 11'h040, num: 12'd8, lo: 3, hi: 6, s2: 0, exp_done: 14};
        tbl[2] = '{base: 11'h7FE, num: 12'd4, lo: 0, hi: 0, s2: 0, exp_done: 6};
        tbl[3] = '{base: 11'h123, num: 12'd0, lo: 0, hi: 0, s2: 0, exp_done: 1};
        tbl[4] = '{base: 11'h200, num: 12'd6, lo: 0, hi: 0, s2: 3, exp_done: 8};
        tbl[5] = '{base: 11'h555, num: 12'd3, lo: 1, hi: 5, s2: 0, exp_done: 9};

        reset = 1'b1;
        i_start = 1'b0;
        i_base_addr = '0;
        i_num_vec = '0;
        i_l0_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk(!o_sram_ren, "rst_ren", o_sram_ren, 0);
        chk(o_sram_addr === '0, "rst_addr", o_sram_addr, 0);
        chk(!o_l0_wr, "rst_wr", o_l0_wr, 0);
        chk(o_l0_in === '0, "rst_l0_in", o_l0_in, 0);
        chk(!o_busy && !o_done, "rst_busy_done", {o_busy, o_done}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int t = 0; t < 6; t++)
            run_scn(tbl[t]);

        // Reset abort with one word buffered, then a fresh short run.
        @(negedge clk);
        i_start = 1'b1;
        i_base_addr = 11'h020;
        i_num_vec = 12'd8;
        i_l0_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        i_l0_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk(!o_sram_ren && !o_l0_wr, "abort_ren_wr", {o_sram_ren, o_l0_wr}, 0);
        chk(o_sram_addr === '0 && o_l0_in === '0, "abort_bus",
            o_l0_in, 0);
        chk(!o_busy && !o_done, "abort_busy_done", {o_busy, o_done}, 0);
        @(negedge clk);
        reset = 1'b0;
        i_l0_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk(!o_done && !o_l0_wr && !o_busy, "abort_quiet",
                {o_busy, o_done, o_l0_wr}, 0);
        end
        run_scn('{base: 11'h010, num: 12'd2, lo: 0, hi: 0, s2: 0, exp_done: 4});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
